// File: rtl/text_pkg.sv
// Shared definitions for the text bit serializer: ASCII constants, the
// serializer FSM state type and the character mapping function.
package text_pkg;

    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_DQUOTE = 8'h22;
    localparam logic [7:0] ASCII_BSLASH = 8'h5C;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       subst;
    } map_result_t;

    // Printable characters pass through, newline becomes carriage return,
    // quote, backslash and anything non-printable become a flagged space.
    function automatic map_result_t map_char(input logic [7:0] c);
        map_result_t r;
        if (c == ASCII_LF) begin
            r.code  = ASCII_CR;
            r.subst = 1'b0;
        end else if (c >= 8'h20 && c <= 8'h7E &&
                     c != ASCII_DQUOTE && c != ASCII_BSLASH) begin
            r.code  = c;
            r.subst = 1'b0;
        end else begin
            r.code  = ASCII_SPACE;
            r.subst = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/text_char_fifo.sv
// Character FIFO, DEPTH x 8, with occupancy count. DEPTH must be a power
// of two so the pointers wrap naturally.
module text_char_fifo
    import text_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [7:0]       wr_data,
    input  logic             pop,
    output logic [7:0]       rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; data is not reset, only the pointers qualify it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/text_bit_serializer.sv
// Text bit serializer: maps incoming characters, queues them and shifts
// each one out as a handshaked serial bitstream.
// Optional build macro TEXT_SER_PARITY_EN appends one even-parity bit
// after every character.
module text_bit_serializer
    import text_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int CHAR_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [7:0]                   in_char,
    output logic                         in_ready,
    output logic                         bit_valid,
    output logic                         bit_out,
    input  logic                         bit_ready,
    output logic                         char_start,
    output logic                         char_last,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         subst_flag,
    output logic                         busy
);

    localparam int         CNT_W    = $clog2(DEPTH + 1);
    localparam logic [2:0] IDX_LAST = 3'(CHAR_W - 1);
`ifdef TEXT_SER_PARITY_EN
    localparam logic [7:0] CHAR_MASK = (CHAR_W == 7) ? 8'h7F : 8'hFF;
`endif

    map_result_t mapped;
    ser_state_t  state;
    logic [7:0]  shreg;
    logic [2:0]  idx;
    logic        en_q;
    logic        push;
    logic        pop;
    logic        adv;
    logic        last_data;
    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  head;
`ifdef TEXT_SER_PARITY_EN
    logic        par_q;
`endif

    // Bit of a character presented at position i of its transmission order.
    function automatic logic sel_bit(input logic [7:0] c, input logic [2:0] i);
        if (MSB_FIRST != 0) begin
            return c[IDX_LAST - i];
        end
        return c[i];
    endfunction

    assign mapped    = map_char(in_char);
    assign in_ready  = en_q && !fifo_full;
    assign push      = in_valid && in_ready;
    assign adv       = bit_valid && bit_ready;
    assign last_data = (idx == IDX_LAST);
    assign busy      = !fifo_empty || (state != IDLE);

    text_char_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (mapped.code),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Hold in_ready low until the first clock after reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= 1'b1;
        end
    end

    // One-cycle pulse for every accepted character that was replaced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            subst_flag <= 1'b0;
        end else begin
            subst_flag <= push && mapped.subst;
        end
    end

    // Load the next character whenever the shifter is free or just finishing.
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !fifo_empty;
`ifdef TEXT_SER_PARITY_EN
            PARITY:  pop = !fifo_empty && adv;
`else
            SHIFT:   pop = !fifo_empty && adv && last_data;
`endif
            default: pop = 1'b0;
        endcase
    end

    // Serializer FSM with registered bit-stream outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            bit_valid  <= 1'b0;
            bit_out    <= 1'b0;
            char_start <= 1'b0;
            char_last  <= 1'b0;
`ifdef TEXT_SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else if (pop) begin
            state      <= SHIFT;
            shreg      <= head;
            idx        <= '0;
            bit_valid  <= 1'b1;
            bit_out    <= sel_bit(head, 3'd0);
            char_start <= 1'b1;
            char_last  <= 1'b0;
`ifdef TEXT_SER_PARITY_EN
            par_q      <= ^(head & CHAR_MASK);
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (adv) begin
                        if (last_data) begin
`ifdef TEXT_SER_PARITY_EN
                            state      <= PARITY;
                            bit_out    <= par_q;
                            char_start <= 1'b0;
                            char_last  <= 1'b1;
`else
                            state      <= IDLE;
                            bit_valid  <= 1'b0;
                            bit_out    <= 1'b0;
                            char_start <= 1'b0;
                            char_last  <= 1'b0;
`endif
                        end else begin
                            idx        <= idx + 3'd1;
                            bit_out    <= sel_bit(shreg, idx + 3'd1);
                            char_start <= 1'b0;
`ifdef TEXT_SER_PARITY_EN
                            char_last  <= 1'b0;
`else
                            char_last  <= ((idx + 3'd1) == IDX_LAST);
`endif
                        end
                    end
                end
`ifdef TEXT_SER_PARITY_EN
                PARITY: begin
                    if (adv) begin
                        state      <= IDLE;
                        bit_valid  <= 1'b0;
                        bit_out    <= 1'b0;
                        char_start <= 1'b0;
                        char_last  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_bit_serializer.sv
// Directed testbench for text_bit_serializer (default build, and the
// TEXT_SER_PARITY_EN build with CHAR_W=7, LSB first).
module tb_text_bit_serializer;

    localparam int DEPTH = 8;
`ifdef TEXT_SER_PARITY_EN
    localparam int CHAR_W    = 7;
    localparam int MSB_FIRST = 0;
    localparam int PAR       = 1;
`else
    localparam int CHAR_W    = 8;
    localparam int MSB_FIRST = 1;
    localparam int PAR       = 0;
`endif
    localparam int NB       = CHAR_W + PAR;
    localparam int WAIT_MAX = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic       in_ready;
    logic       bit_valid;
    logic       bit_out;
    logic       bit_ready = 1'b0;
    logic       char_start;
    logic       char_last;
    logic [3:0] fifo_count;
    logic       subst_flag;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    text_bit_serializer #(
        .DEPTH     (DEPTH),
        .CHAR_W    (CHAR_W),
        .MSB_FIRST (MSB_FIRST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .in_ready   (in_ready),
        .bit_valid  (bit_valid),
        .bit_out    (bit_out),
        .bit_ready  (bit_ready),
        .char_start (char_start),
        .char_last  (char_last),
        .fifo_count (fifo_count),
        .subst_flag (subst_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Receive one character (bit_ready must be 1); reports framing problems.
    task automatic get_char(output logic [7:0] code, output logic par,
                            output logic frame_ok, output int waited);
        code = 8'h00;
        par = 1'b0;
        frame_ok = 1'b1;
        waited = 0;
        while (!bit_valid && waited < WAIT_MAX) begin
            step();
            waited++;
        end
        if (!bit_valid) begin
            frame_ok = 1'b0;
            return;
        end
        for (int i = 0; i < NB; i++) begin
            if (!bit_valid || char_start !== (i == 0) || char_last !== (i == NB - 1))
                frame_ok = 1'b0;
            if (i < CHAR_W) begin
                if (MSB_FIRST != 0) code[CHAR_W - 1 - i] = bit_out;
                else code[i] = bit_out;
            end else begin
                par = bit_out;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({bit_valid, bit_out, char_start, char_last, subst_flag, busy, in_ready} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {bit_valid, bit_out, char_start, char_last, subst_flag, busy, in_ready});
        end
        n_checks++;
        if (fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", fifo_count);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single_char();
        logic [7:0] c;
        c = 8'h41;
        bit_ready = 1'b1;
        in_char = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b1 || subst_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after_push: valid=%b busy=%b subst=%b expected 0 1 0",
                     bit_valid, busy, subst_flag);
        end
        step();
        n_checks++;
        if (bit_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: bit_valid=%b expected 1", bit_valid);
        end
        for (int i = 0; i < NB; i++) begin
            logic eb;
            if (i < CHAR_W) eb = (MSB_FIRST != 0) ? c[CHAR_W - 1 - i] : c[i];
            else eb = 1'b0;
            n_checks++;
            if (bit_out !== eb || char_start !== (i == 0) || char_last !== (i == NB - 1) || bit_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL single_bit%0d: got bit=%b start=%b last=%b valid=%b expected bit=%b start=%b last=%b valid=1",
                         i, bit_out, char_start, char_last, bit_valid, eb, i == 0, i == NB - 1);
            end
            step();
        end
        n_checks++;
        if (busy !== 1'b0 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: busy=%b valid=%b expected 0 0", busy, bit_valid);
        end
    endtask

    task automatic test_mapping();
        logic [7:0] vin  [3];
        logic [7:0] vexp [3];
        logic       vsub [3];
        logic [1:0] vpar [3];
        logic [7:0] code;
        logic       par;
        logic       ok;
        int         w;
        vin = '{8'h0A, 8'h5C, 8'h01};
        vexp = '{8'h0D, 8'h20, 8'h20};
        vsub = '{1'b0, 1'b1, 1'b1};
        vpar = '{2'd1, 2'd1, 2'd1};
        bit_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_char = vin[k];
            in_valid = 1'b1;
            step();
            n_checks++;
            if (subst_flag !== vsub[k]) begin
                n_fail++;
                $display("FAIL map_subst_%02h: got %b expected %b", vin[k], subst_flag, vsub[k]);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (subst_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL map_subst_idle: got %b expected 0", subst_flag);
        end
        bit_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            get_char(code, par, ok, w);
            n_checks++;
            if (code !== vexp[k] || ok !== 1'b1) begin
                n_fail++;
                $display("FAIL map_code_%02h: got %02h frame=%b expected %02h frame=1", vin[k], code, ok, vexp[k]);
            end
            if (PAR != 0) begin
                n_checks++;
                if (par !== vpar[k][0]) begin
                    n_fail++;
                    $display("FAIL map_parity_%02h: got %b expected %b", vin[k], par, vpar[k][0]);
                end
            end
        end
    endtask

    task automatic test_full();
        logic [7:0] rx [10];
        logic       b0;
        logic       all_ok;
        logic       pushed_ok;
        bit_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            in_char = 8'h41 + 8'(k);
            in_valid = 1'b1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL full_ready_before_%0d: got %b expected 1", k, in_ready);
            end
            step();
        end
        n_checks++;
        if (fifo_count !== 4'd8 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_reached: count=%0d ready=%b expected 8 0", fifo_count, in_ready);
        end
        in_char = 8'h4A;
        b0 = bit_out;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (fifo_count !== 4'd8 || in_ready !== 1'b0 || bit_valid !== 1'b1 || bit_out !== b0) begin
                n_fail++;
                $display("FAIL full_hold_%0d: count=%0d ready=%b valid=%b bit=%b expected 8 0 1 %b",
                         k, fifo_count, in_ready, bit_valid, bit_out, b0);
            end
        end
        bit_ready = 1'b1;
        all_ok = 1'b1;
        pushed_ok = 1'b0;
        fork
            begin
                int n;
                n = 0;
                while (!in_ready && n < 300) begin
                    step();
                    n++;
                end
                pushed_ok = in_ready;
                step();
                in_valid = 1'b0;
            end
            begin
                logic par;
                logic ok;
                int   w;
                for (int k = 0; k < 10; k++) begin
                    get_char(rx[k], par, ok, w);
                    if (!ok) all_ok = 1'b0;
                end
            end
        join
        n_checks++;
        if (pushed_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL full_tenth_accepted: got %b expected 1", pushed_ok);
        end
        n_checks++;
        if (all_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL full_framing: got %b expected 1", all_ok);
        end
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (rx[k] !== 8'h41 + 8'(k)) begin
                n_fail++;
                $display("FAIL full_order_%0d: got %02h expected %02h", k, rx[k], 8'h41 + 8'(k));
            end
        end
        n_checks++;
        if (busy !== 1'b0 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL full_drained: busy=%b count=%0d expected 0 0", busy, fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] c1;
        logic [7:0] c2;
        logic       p1;
        logic       p2;
        logic       ok1;
        logic       ok2;
        int         w1;
        int         w2;
        bit_ready = 1'b1;
        in_char = 8'h48;
        in_valid = 1'b1;
        step();
        in_char = 8'h69;
        step();
        in_valid = 1'b0;
        get_char(c1, p1, ok1, w1);
        get_char(c2, p2, ok2, w2);
        n_checks++;
        if (c1 !== 8'h48 || c2 !== 8'h69) begin
            n_fail++;
            $display("FAIL b2b_codes: got %02h %02h expected 48 69", c1, c2);
        end
        n_checks++;
        if (ok1 !== 1'b1 || ok2 !== 1'b1 || w2 != 0) begin
            n_fail++;
            $display("FAIL b2b_contiguous: frames=%b%b gap=%0d expected 11 gap=0", ok1, ok2, w2);
        end
        n_checks++;
        if (bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: bit_valid=%b expected 0", bit_valid);
        end
    endtask

    task automatic test_stall();
        logic [7:0] code;
        logic       par;
        logic       held;
        logic       hv;
        int         n;
        int         cyc;
        code = 8'h00;
        par = 1'b0;
        n = 0;
        cyc = 0;
        bit_ready = 1'b0;
        in_char = 8'h5A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        while (n < NB && cyc < 300) begin
            bit_ready = (cyc < 3) ? 1'b0 : 1'($urandom_range(0, 1));
            if (bit_valid && bit_ready) begin
                if (n < CHAR_W) begin
                    if (MSB_FIRST != 0) code[CHAR_W - 1 - n] = bit_out;
                    else code[n] = bit_out;
                end else begin
                    par = bit_out;
                end
                n++;
                step();
            end else begin
                held = bit_out;
                hv = bit_valid;
                step();
                if (hv) begin
                    n_checks++;
                    if (bit_out !== held || bit_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall_hold: bit=%b valid=%b expected %b 1", bit_out, bit_valid, held);
                    end
                end
            end
            cyc++;
        end
        bit_ready = 1'b1;
        n_checks++;
        if (n != NB || code !== 8'h5A || (PAR != 0 && par !== 1'b0)) begin
            n_fail++;
            $display("FAIL stall_sequence: got %02h par=%b bits=%0d expected 5a par=0 bits=%0d",
                     code, par, n, NB);
        end
    endtask

`ifdef TEXT_SER_PARITY_EN
    task automatic test_parity();
        logic [7:0] code;
        logic       par;
        logic       ok;
        int         w;
        bit_ready = 1'b1;
        in_char = 8'h43;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        get_char(code, par, ok, w);
        n_checks++;
        if (code !== 8'h43 || par !== 1'b1 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_C: got %02h par=%b frame=%b expected 43 par=1 frame=1", code, par, ok);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int stray;
        bit_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_char = 8'h31 + 8'(k);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 4'd2) begin
            n_fail++;
            $display("FAIL rmid_precount: got %0d expected 2", fifo_count);
        end
        bit_ready = 1'b1;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({bit_valid, bit_out, char_start, char_last, subst_flag, busy, in_ready} !== 7'b0 ||
            fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got %b count=%0d expected 0000000 count=0",
                     {bit_valid, bit_out, char_start, char_last, subst_flag, busy, in_ready}, fifo_count);
        end
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bit_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL rmid_no_bits: got %0d active cycles expected 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_mapping();
        test_full();
        test_back_to_back();
        test_stall();
`ifdef TEXT_SER_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
